// File: rtl/core_rvfi_trace_fifo.sv
// -----------------------------------------------------------------------------
// core_rvfi_trace_fifo
//
// Purpose:
//   Captures every retired-instruction RVFI packet from the core's RVFI output
//   stage into a DEPTH-entry FIFO. The FIFO drains to a trace sink (formal
//   harness, testbench monitor or trace DMA) over a valid/ready stream.
//   Packets that arrive while the FIFO is full and not draining are dropped
//   and counted. The next accepted packet carries a gap marker. The module
//   also watches rvfi_order and raises a sticky error on any non-consecutive
//   retirement index. The instantiating core only builds this block when RVFI
//   is defined.
//
// Configuration macro:
//   RVFI_TRACE_MEM_EN - adds the rvfi_mem_* ports and appends the memory
//                       fields to the packet above the gap bit.
//
// Ports:
//   g_clk, g_resetn     clock, synchronous active-low reset
//   rvfi_*              RVFI retirement packet from the core (rvfi_valid strobe)
//   t_valid / t_ready   trace stream handshake (head packet on t_data)
//   t_data              registered head entry, PKT_W bits
//   t_level             current FIFO occupancy
//   drop_count          saturating count of packets lost to overflow
//   err_order           sticky flag, non-consecutive rvfi_order seen
//
// Packet layout (LSB first):
//   order[63:0], pc_rdata, pc_wdata, rd_wdata, insn[31:0], rd_addr[4:0],
//   mode[1:0], trap, intr, gap, [mem_addr, mem_rmask, mem_wmask, mem_rdata,
//   mem_wdata], spare. The MSB is a spare bit that always reads zero, so
//   PKT_W = 3*XLEN+107 (+3*XLEN+XLEN/4 with memory fields).
// -----------------------------------------------------------------------------
module core_rvfi_trace_fifo #(
   parameter int XLEN   = 64,
   parameter int DEPTH  = 8,
   parameter int DROP_W = 16,
`ifdef RVFI_TRACE_MEM_EN
   localparam int MEM_W = 3*XLEN + XLEN/4,
`else
   localparam int MEM_W = 0,
`endif
   localparam int PKT_W = 3*XLEN + 107 + MEM_W,
   localparam int LVL_W = $clog2(DEPTH) + 1
) (
   input  logic              g_clk,
   input  logic              g_resetn,
   input  logic              rvfi_valid,
   input  logic [63:0]       rvfi_order,
   input  logic [31:0]       rvfi_insn,
   input  logic              rvfi_trap,
   input  logic              rvfi_intr,
   input  logic [1:0]        rvfi_mode,
   input  logic [XLEN-1:0]   rvfi_pc_rdata,
   input  logic [XLEN-1:0]   rvfi_pc_wdata,
   input  logic [4:0]        rvfi_rd_addr,
   input  logic [XLEN-1:0]   rvfi_rd_wdata,
`ifdef RVFI_TRACE_MEM_EN
   input  logic [XLEN-1:0]   rvfi_mem_addr,
   input  logic [XLEN/8-1:0] rvfi_mem_rmask,
   input  logic [XLEN/8-1:0] rvfi_mem_wmask,
   input  logic [XLEN-1:0]   rvfi_mem_rdata,
   input  logic [XLEN-1:0]   rvfi_mem_wdata,
`endif
   output logic              t_valid,
   input  logic              t_ready,
   output logic [PKT_W-1:0]  t_data,
   output logic [LVL_W-1:0]  t_level,
   output logic [DROP_W-1:0] drop_count,
   output logic              err_order
);

   localparam int PTR_W = $clog2(DEPTH);

   // Field offsets within a packet
   localparam int OFF_ORDER    = 0;
   localparam int OFF_PC_RDATA = 64;
   localparam int OFF_PC_WDATA = OFF_PC_RDATA + XLEN;
   localparam int OFF_RD_WDATA = OFF_PC_WDATA + XLEN;
   localparam int OFF_INSN     = OFF_RD_WDATA + XLEN;
   localparam int OFF_RD_ADDR  = OFF_INSN + 32;
   localparam int OFF_MODE     = OFF_RD_ADDR + 5;
   localparam int OFF_TRAP     = OFF_MODE + 2;
   localparam int OFF_INTR     = OFF_TRAP + 1;
   localparam int OFF_GAP      = OFF_INTR + 1;
`ifdef RVFI_TRACE_MEM_EN
   localparam int OFF_MEM_ADDR  = OFF_GAP + 1;
   localparam int OFF_MEM_RMASK = OFF_MEM_ADDR + XLEN;
   localparam int OFF_MEM_WMASK = OFF_MEM_RMASK + XLEN/8;
   localparam int OFF_MEM_RDATA = OFF_MEM_WMASK + XLEN/8;
   localparam int OFF_MEM_WDATA = OFF_MEM_RDATA + XLEN;
`endif

   // Saturating increment for the drop counter
   function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
      return (&v) ? v : v + DROP_W'(1);
   endfunction

   logic [PKT_W-1:0] fifo_mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [LVL_W-1:0] level;
   logic             gap_pending;
   logic             base_vld;
   logic [63:0]      last_order;

   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic             overflow;
   logic             order_gap;
   logic [PKT_W-1:0] wr_pkt;

   // ---- Input stage: accept/drop decision and packet assembly ----
   assign full     = (level == LVL_W'(DEPTH));
   assign empty    = (level == '0);
   assign pop      = !empty && t_ready;
   // A full FIFO still accepts when the head leaves in the same cycle.
   assign push     = rvfi_valid && (!full || pop);
   assign overflow = rvfi_valid && full && !pop;

   // The order check sees every retirement, including dropped ones, so an
   // overflow alone never looks like an order gap.
   assign order_gap = base_vld && (rvfi_order != (last_order + 64'd1));

   always_comb begin
      wr_pkt = '0;
      wr_pkt[OFF_ORDER    +: 64]   = rvfi_order;
      wr_pkt[OFF_PC_RDATA +: XLEN] = rvfi_pc_rdata;
      wr_pkt[OFF_PC_WDATA +: XLEN] = rvfi_pc_wdata;
      wr_pkt[OFF_RD_WDATA +: XLEN] = rvfi_rd_wdata;
      wr_pkt[OFF_INSN     +: 32]   = rvfi_insn;
      wr_pkt[OFF_RD_ADDR  +: 5]    = rvfi_rd_addr;
      wr_pkt[OFF_MODE     +: 2]    = rvfi_mode;
      wr_pkt[OFF_TRAP]             = rvfi_trap;
      wr_pkt[OFF_INTR]             = rvfi_intr;
      wr_pkt[OFF_GAP]              = gap_pending;
`ifdef RVFI_TRACE_MEM_EN
      wr_pkt[OFF_MEM_ADDR  +: XLEN]   = rvfi_mem_addr;
      wr_pkt[OFF_MEM_RMASK +: XLEN/8] = rvfi_mem_rmask;
      wr_pkt[OFF_MEM_WMASK +: XLEN/8] = rvfi_mem_wmask;
      wr_pkt[OFF_MEM_RDATA +: XLEN]   = rvfi_mem_rdata;
      wr_pkt[OFF_MEM_WDATA +: XLEN]   = rvfi_mem_wdata;
`endif
   end

   // ---- Storage stage: packet array (data only, never reset) ----
   always_ff @(posedge g_clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= wr_pkt;
      end
   end

   // ---- Control state: pointers, occupancy, drop tracking, order check ----
   always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         level       <= '0;
         gap_pending <= 1'b0;
         drop_count  <= '0;
         err_order   <= 1'b0;
         base_vld    <= 1'b0;
         last_order  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end

         case ({push, pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase

         // Overflow and an accepted push are mutually exclusive, so the
         // gap marker is either armed or consumed, never both.
         if (overflow) begin
            drop_count  <= sat_inc(drop_count);
            gap_pending <= 1'b1;
         end else if (push) begin
            gap_pending <= 1'b0;
         end

         if (rvfi_valid) begin
            base_vld   <= 1'b1;
            last_order <= rvfi_order;
            if (order_gap) begin
               err_order <= 1'b1;
            end
         end
      end
   end

   // ---- Output stage: registered head entry ----
   assign t_valid = !empty;
   assign t_data  = fifo_mem[rd_ptr];
   assign t_level = level;

endmodule

// File: tb/tb_core_rvfi_trace_fifo.sv
// -----------------------------------------------------------------------------
// tb_core_rvfi_trace_fifo
//
// Self-checking bench for core_rvfi_trace_fifo (default parameters). A
// reference FIFO model predicts every drained packet. Each accepted push
// appends an expected packet. Each handshake moves the model head onto an
// expected-output queue. The DUT head observed at the same handshake goes
// onto an observed queue, and each scenario task compares the two.
// Build with RVFI_TRACE_MEM_EN defined to exercise the memory fields.
// -----------------------------------------------------------------------------
module tb_core_rvfi_trace_fifo;

   localparam int XLEN  = 64;
   localparam int DEPTH = 8;
`ifdef RVFI_TRACE_MEM_EN
   localparam int MEM_W = 3*XLEN + XLEN/4;
`else
   localparam int MEM_W = 0;
`endif
   localparam int PKT_W = 3*XLEN + 107 + MEM_W;

   localparam int O_ORDER = 0;
   localparam int O_PCR   = 64;
   localparam int O_PCW   = 64 + XLEN;
   localparam int O_RDW   = 64 + 2*XLEN;
   localparam int O_INSN  = 64 + 3*XLEN;
   localparam int O_RDA   = 96 + 3*XLEN;
   localparam int O_MODE  = 101 + 3*XLEN;
   localparam int O_TRAP  = 103 + 3*XLEN;
   localparam int O_INTR  = 104 + 3*XLEN;
   localparam int O_GAP   = 105 + 3*XLEN;
`ifdef RVFI_TRACE_MEM_EN
   localparam int O_MADDR  = 106 + 3*XLEN;
   localparam int O_MRMASK = 106 + 4*XLEN;
   localparam int O_MWMASK = 106 + 4*XLEN + XLEN/8;
   localparam int O_MRDATA = 106 + 4*XLEN + XLEN/4;
   localparam int O_MWDATA = 106 + 5*XLEN + XLEN/4;
`endif

   logic              g_clk = 1'b0;
   logic              g_resetn;
   logic              rvfi_valid;
   logic [63:0]       rvfi_order;
   logic [31:0]       rvfi_insn;
   logic              rvfi_trap;
   logic              rvfi_intr;
   logic [1:0]        rvfi_mode;
   logic [XLEN-1:0]   rvfi_pc_rdata;
   logic [XLEN-1:0]   rvfi_pc_wdata;
   logic [4:0]        rvfi_rd_addr;
   logic [XLEN-1:0]   rvfi_rd_wdata;
`ifdef RVFI_TRACE_MEM_EN
   logic [XLEN-1:0]   rvfi_mem_addr;
   logic [XLEN/8-1:0] rvfi_mem_rmask;
   logic [XLEN/8-1:0] rvfi_mem_wmask;
   logic [XLEN-1:0]   rvfi_mem_rdata;
   logic [XLEN-1:0]   rvfi_mem_wdata;
`endif
   logic              t_valid;
   logic              t_ready;
   logic [PKT_W-1:0]  t_data;
   logic [3:0]        t_level;
   logic [15:0]       drop_count;
   logic              err_order;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [PKT_W-1:0] m_fifo[$];
   logic [PKT_W-1:0] exp_q[$];
   logic [PKT_W-1:0] obs_q[$];
   bit               m_gap;
   logic [PKT_W-1:0] o_pkt;
   logic [PKT_W-1:0] e_pkt;

   core_rvfi_trace_fifo dut (
      .g_clk         (g_clk),
      .g_resetn      (g_resetn),
      .rvfi_valid    (rvfi_valid),
      .rvfi_order    (rvfi_order),
      .rvfi_insn     (rvfi_insn),
      .rvfi_trap     (rvfi_trap),
      .rvfi_intr     (rvfi_intr),
      .rvfi_mode     (rvfi_mode),
      .rvfi_pc_rdata (rvfi_pc_rdata),
      .rvfi_pc_wdata (rvfi_pc_wdata),
      .rvfi_rd_addr  (rvfi_rd_addr),
      .rvfi_rd_wdata (rvfi_rd_wdata),
`ifdef RVFI_TRACE_MEM_EN
      .rvfi_mem_addr (rvfi_mem_addr),
      .rvfi_mem_rmask(rvfi_mem_rmask),
      .rvfi_mem_wmask(rvfi_mem_wmask),
      .rvfi_mem_rdata(rvfi_mem_rdata),
      .rvfi_mem_wdata(rvfi_mem_wdata),
`endif
      .t_valid       (t_valid),
      .t_ready       (t_ready),
      .t_data        (t_data),
      .t_level       (t_level),
      .drop_count    (drop_count),
      .err_order     (err_order)
   );

   always #5 g_clk = ~g_clk;

   // Reference model, evaluated at each rising edge on the driven inputs
   task automatic model_step();
      logic [PKT_W-1:0] p;
      bit pop, full;
      if (!g_resetn) begin
         m_fifo.delete();
         m_gap = 1'b0;
         return;
      end
      pop  = (m_fifo.size() != 0) && t_ready;
      full = (m_fifo.size() == DEPTH);
      if (pop) exp_q.push_back(m_fifo.pop_front());
      if (rvfi_valid) begin
         if (!full || pop) begin
            p = '0;
            p[O_ORDER +: 64]   = rvfi_order;
            p[O_PCR   +: XLEN] = rvfi_pc_rdata;
            p[O_PCW   +: XLEN] = rvfi_pc_wdata;
            p[O_RDW   +: XLEN] = rvfi_rd_wdata;
            p[O_INSN  +: 32]   = rvfi_insn;
            p[O_RDA   +: 5]    = rvfi_rd_addr;
            p[O_MODE  +: 2]    = rvfi_mode;
            p[O_TRAP]          = rvfi_trap;
            p[O_INTR]          = rvfi_intr;
            p[O_GAP]           = m_gap;
`ifdef RVFI_TRACE_MEM_EN
            p[O_MADDR  +: XLEN]   = rvfi_mem_addr;
            p[O_MRMASK +: XLEN/8] = rvfi_mem_rmask;
            p[O_MWMASK +: XLEN/8] = rvfi_mem_wmask;
            p[O_MRDATA +: XLEN]   = rvfi_mem_rdata;
            p[O_MWDATA +: XLEN]   = rvfi_mem_wdata;
`endif
            m_fifo.push_back(p);
            m_gap = 1'b0;
         end else begin
            m_gap = 1'b1;
         end
      end
   endtask

   // One clock: observe the handshake at the falling edge, update the model
   // at the rising edge, then return 1 time unit after it.
   task automatic tick();
      @(negedge g_clk);
      if (g_resetn && t_valid && t_ready) obs_q.push_back(t_data);
      @(posedge g_clk);
      model_step();
      #1;
   endtask

   task automatic set_in(input bit v, input logic [63:0] ord);
      rvfi_valid    = v;
      rvfi_order    = ord;
      rvfi_insn     = $urandom;
      rvfi_trap     = 1'($urandom);
      rvfi_intr     = 1'($urandom);
      rvfi_mode     = 2'($urandom);
      rvfi_pc_rdata = {$urandom, $urandom};
      rvfi_pc_wdata = {$urandom, $urandom};
      rvfi_rd_addr  = 5'($urandom);
      rvfi_rd_wdata = {$urandom, $urandom};
`ifdef RVFI_TRACE_MEM_EN
      rvfi_mem_addr  = {$urandom, $urandom};
      rvfi_mem_rmask = 8'($urandom);
      rvfi_mem_wmask = 8'($urandom);
      rvfi_mem_rdata = {$urandom, $urandom};
      rvfi_mem_wdata = {$urandom, $urandom};
`endif
   endtask

   task automatic do_reset();
      g_resetn = 1'b0;
      t_ready  = 1'b0;
      set_in(1'b0, 64'd0);
      tick();
      tick();
      g_resetn = 1'b1;
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (t_valid !== 1'b0) begin n_fail++; $display("FAIL reset_t_valid got %b want 0", t_valid); end
      n_cmp++; if (t_level !== 4'd0) begin n_fail++; $display("FAIL reset_t_level got %0d want 0", t_level); end
      n_cmp++; if (drop_count !== 16'd0) begin n_fail++; $display("FAIL reset_drop got %0d want 0", drop_count); end
      n_cmp++; if (err_order !== 1'b0) begin n_fail++; $display("FAIL reset_err_order got %b want 0", err_order); end
   endtask

   task automatic test_in_order();
      do_reset();
      t_ready = 1'b1;
      set_in(1'b1, 64'd0);
      n_cmp++; if (t_valid !== 1'b0) begin n_fail++; $display("FAIL inord_no_bypass got %b want 0", t_valid); end
      tick();
      n_cmp++; if (t_valid !== 1'b1) begin n_fail++; $display("FAIL inord_latency got %b want 1", t_valid); end
      set_in(1'b1, 64'd1); tick();
      set_in(1'b1, 64'd2); tick();
      set_in(1'b0, 64'd0); tick(); tick();
      n_cmp++; if (obs_q.size() != 3) begin n_fail++; $display("FAIL inord_count got %0d want 3", obs_q.size()); end
      for (int i = 0; obs_q.size() > 0 && exp_q.size() > 0; i++) begin
         o_pkt = obs_q.pop_front(); e_pkt = exp_q.pop_front();
         n_cmp++; if (o_pkt !== e_pkt) begin n_fail++; $display("FAIL inord_pkt%0d got %h want %h", i, o_pkt, e_pkt); end
         n_cmp++; if (o_pkt[O_ORDER +: 64] !== 64'(i)) begin n_fail++; $display("FAIL inord_order%0d got %0d want %0d", i, o_pkt[O_ORDER +: 64], i); end
      end
      n_cmp++; if (err_order !== 1'b0) begin n_fail++; $display("FAIL inord_err got %b want 0", err_order); end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < 10; i++) begin set_in(1'b1, 64'(i)); tick(); end
      set_in(1'b0, 64'd0);
      n_cmp++; if (t_level !== 4'd8) begin n_fail++; $display("FAIL ovf_level got %0d want 8", t_level); end
      n_cmp++; if (drop_count !== 16'd2) begin n_fail++; $display("FAIL ovf_drop got %0d want 2", drop_count); end
      n_cmp++; if (t_data !== m_fifo[0]) begin n_fail++; $display("FAIL ovf_head_hold got %h want %h", t_data, m_fifo[0]); end
      t_ready = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      n_cmp++; if (t_level !== 4'd0) begin n_fail++; $display("FAIL ovf_drained got %0d want 0", t_level); end
      set_in(1'b1, 64'd10); tick();
      set_in(1'b0, 64'd0); tick(); tick();
      n_cmp++; if (obs_q.size() != 9) begin n_fail++; $display("FAIL ovf_count got %0d want 9", obs_q.size()); end
      for (int i = 0; obs_q.size() > 0 && exp_q.size() > 0; i++) begin
         o_pkt = obs_q.pop_front(); e_pkt = exp_q.pop_front();
         n_cmp++; if (o_pkt !== e_pkt) begin n_fail++; $display("FAIL ovf_pkt%0d got %h want %h", i, o_pkt, e_pkt); end
      end
      n_cmp++; if (o_pkt[O_GAP] !== 1'b1) begin n_fail++; $display("FAIL ovf_gap got %b want 1", o_pkt[O_GAP]); end
      n_cmp++; if (err_order !== 1'b0) begin n_fail++; $display("FAIL ovf_err got %b want 0", err_order); end
   endtask

   task automatic test_full_pop();
      do_reset();
      for (int i = 0; i < 8; i++) begin set_in(1'b1, 64'(i)); tick(); end
      n_cmp++; if (t_level !== 4'd8) begin n_fail++; $display("FAIL fullpop_fill got %0d want 8", t_level); end
      set_in(1'b1, 64'd8);
      t_ready = 1'b1;
      tick();
      n_cmp++; if (t_level !== 4'd8) begin n_fail++; $display("FAIL fullpop_level got %0d want 8", t_level); end
      n_cmp++; if (drop_count !== 16'd0) begin n_fail++; $display("FAIL fullpop_drop got %0d want 0", drop_count); end
      set_in(1'b0, 64'd0);
      for (int i = 0; i < 8; i++) tick();
      n_cmp++; if (obs_q.size() != 9) begin n_fail++; $display("FAIL fullpop_count got %0d want 9", obs_q.size()); end
      for (int i = 0; obs_q.size() > 0 && exp_q.size() > 0; i++) begin
         o_pkt = obs_q.pop_front(); e_pkt = exp_q.pop_front();
         n_cmp++; if (o_pkt !== e_pkt) begin n_fail++; $display("FAIL fullpop_pkt%0d got %h want %h", i, o_pkt, e_pkt); end
      end
   endtask

   task automatic test_order_gap();
      do_reset();
      t_ready = 1'b1;
      set_in(1'b1, 64'd5); tick();
      set_in(1'b1, 64'd6); tick();
      n_cmp++; if (err_order !== 1'b0) begin n_fail++; $display("FAIL gap_before got %b want 0", err_order); end
      set_in(1'b1, 64'd8); tick();
      n_cmp++; if (err_order !== 1'b1) begin n_fail++; $display("FAIL gap_detect got %b want 1", err_order); end
      set_in(1'b1, 64'd9); tick();
      set_in(1'b1, 64'd10); tick();
      set_in(1'b0, 64'd0); tick();
      n_cmp++; if (err_order !== 1'b1) begin n_fail++; $display("FAIL gap_sticky got %b want 1", err_order); end
      for (int i = 0; obs_q.size() > 0 && exp_q.size() > 0; i++) begin
         o_pkt = obs_q.pop_front(); e_pkt = exp_q.pop_front();
         n_cmp++; if (o_pkt !== e_pkt) begin n_fail++; $display("FAIL gap_pkt%0d got %h want %h", i, o_pkt, e_pkt); end
      end
      do_reset();
      n_cmp++; if (err_order !== 1'b0) begin n_fail++; $display("FAIL gap_reset got %b want 0", err_order); end
   endtask

   task automatic test_order_wrap();
      do_reset();
      t_ready = 1'b1;
      set_in(1'b1, 64'hFFFF_FFFF_FFFF_FFFF); tick();
      set_in(1'b1, 64'd0); tick();
      set_in(1'b1, 64'd1); tick();
      set_in(1'b0, 64'd0); tick(); tick();
      n_cmp++; if (err_order !== 1'b0) begin n_fail++; $display("FAIL wrap_err got %b want 0", err_order); end
      n_cmp++; if (obs_q.size() != 3) begin n_fail++; $display("FAIL wrap_count got %0d want 3", obs_q.size()); end
      for (int i = 0; obs_q.size() > 0 && exp_q.size() > 0; i++) begin
         o_pkt = obs_q.pop_front(); e_pkt = exp_q.pop_front();
         n_cmp++; if (o_pkt !== e_pkt) begin n_fail++; $display("FAIL wrap_pkt%0d got %h want %h", i, o_pkt, e_pkt); end
      end
   endtask

   task automatic test_reset_mid_drain();
      do_reset();
      for (int i = 0; i < 3; i++) begin set_in(1'b1, 64'(i)); tick(); end
      set_in(1'b0, 64'd0);
      t_ready = 1'b1;
      tick();
      n_cmp++; if (t_level !== 4'd2) begin n_fail++; $display("FAIL middrain_level got %0d want 2", t_level); end
      g_resetn = 1'b0;
      tick();
      n_cmp++; if (t_valid !== 1'b0) begin n_fail++; $display("FAIL middrain_valid got %b want 0", t_valid); end
      n_cmp++; if (t_level !== 4'd0) begin n_fail++; $display("FAIL middrain_flush got %0d want 0", t_level); end
      g_resetn = 1'b1;
      tick();
      n_cmp++; if (t_valid !== 1'b0) begin n_fail++; $display("FAIL middrain_after got %b want 0", t_valid); end
      for (int i = 0; obs_q.size() > 0 && exp_q.size() > 0; i++) begin
         o_pkt = obs_q.pop_front(); e_pkt = exp_q.pop_front();
         n_cmp++; if (o_pkt !== e_pkt) begin n_fail++; $display("FAIL middrain_pkt%0d got %h want %h", i, o_pkt, e_pkt); end
      end
   endtask

`ifdef RVFI_TRACE_MEM_EN
   task automatic test_mem_fields();
      do_reset();
      t_ready = 1'b1;
      set_in(1'b1, 64'd0);
      rvfi_mem_wmask = 8'h0F;
      rvfi_mem_wdata = 64'h1234;
      rvfi_mem_rmask = 8'h00;
      tick();
      set_in(1'b0, 64'd0); tick(); tick();
      n_cmp++; if (obs_q.size() != 1) begin n_fail++; $display("FAIL mem_count got %0d want 1", obs_q.size()); end
      if (obs_q.size() > 0 && exp_q.size() > 0) begin
         o_pkt = obs_q.pop_front(); e_pkt = exp_q.pop_front();
         n_cmp++; if (o_pkt !== e_pkt) begin n_fail++; $display("FAIL mem_pkt got %h want %h", o_pkt, e_pkt); end
         n_cmp++; if (o_pkt[O_MWMASK +: 8] !== 8'h0F) begin n_fail++; $display("FAIL mem_wmask got %h want 0f", o_pkt[O_MWMASK +: 8]); end
         n_cmp++; if (o_pkt[O_MWDATA +: 64] !== 64'h1234) begin n_fail++; $display("FAIL mem_wdata got %h want 1234", o_pkt[O_MWDATA +: 64]); end
         n_cmp++; if (o_pkt[O_MRMASK +: 8] !== 8'h00) begin n_fail++; $display("FAIL mem_rmask got %h want 00", o_pkt[O_MRMASK +: 8]); end
      end
   endtask
`endif

   initial begin
      g_resetn = 1'b0;
      t_ready  = 1'b0;
      set_in(1'b0, 64'd0);
      test_reset();
      test_in_order();
      test_overflow();
      test_full_pop();
      test_order_gap();
      test_order_wrap();
      test_reset_mid_drain();
`ifdef RVFI_TRACE_MEM_EN
      test_mem_fields();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
